// File: rtl/seq_inv_25519.sv
// seq_inv_25519 -- sequential modular inverter over GF(2^255-19).
//
// Computes inv = x^(p-2) mod p by left-to-right square-and-multiply, issuing
// every square/multiply to an external sequential field multiplier and
// consuming its reduced product. One inversion owns the multiplier exclusively.
//
// Optional feature macro: SEQ_INV_EXP_PORT_EN
//   defined   : adds input exp[254:0], sampled with start; computes x^exp mod p.
//   undefined : exponent fixed to p-2, no exp port.
//
// Ports:
//   clk          in   1    rising-edge clock
//   rst          in   1    asynchronous active-high reset
//   start        in   1    request, sampled only when idle
//   x            in   256  operand (must be < p), sampled with start
//   exp          in   255  exponent (only with SEQ_INV_EXP_PORT_EN)
//   inv          out  256  result, valid from done until next accepted start
//   done         out  1    one-cycle result-ready pulse
//   busy         out  1    high from cycle after accepted start through done
//   mul_a/mul_b  out  256  multiplier operands, stable from mul_start to mul_done
//   mul_start    out  1    one-cycle multiply launch pulse
//   mul_product  in   256  reduced product from the multiplier
//   mul_done     in   1    one-cycle pulse, mul_product valid
module seq_inv_25519 (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] x,
`ifdef SEQ_INV_EXP_PORT_EN
    input  logic [254:0] exp,
`endif
    output logic [255:0] inv,
    output logic         done,
    output logic         busy,
    output logic [255:0] mul_a,
    output logic [255:0] mul_b,
    output logic         mul_start,
    input  logic [255:0] mul_product,
    input  logic         mul_done
);

    // p - 2 = 2^255 - 21: bits 254..5 set, low bits 01011
    localparam logic [254:0] EXP_P2 = {{250{1'b1}}, 5'b01011};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_SQ_REQ,
        S_SQ_WAIT,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_FIN
    } state_t;

    state_t       r_state, w_state_n;
    logic [255:0] r_acc, w_acc_n;
    logic [255:0] r_base, w_base_n;
    logic [7:0]   r_i, w_i_n;
    logic         r_seen, w_seen_n;
    logic [255:0] r_inv, w_inv_n;
    logic         r_done, w_done_n;
    logic         r_busy, w_busy_n;
    logic         r_mul_start, w_mul_start_n;
    logic [255:0] r_mul_a, w_mul_a_n;
    logic [255:0] r_mul_b, w_mul_b_n;
    logic [254:0] w_exp;
    logic         w_bit;
    logic         w_adv;

`ifdef SEQ_INV_EXP_PORT_EN
    logic [254:0] r_exp, w_exp_n;
    assign w_exp = r_exp;
`else
    assign w_exp = EXP_P2;
`endif

    assign w_bit = w_exp[r_i];

    always_comb begin
        w_state_n     = r_state;
        w_acc_n       = r_acc;
        w_base_n      = r_base;
        w_i_n         = r_i;
        w_seen_n      = r_seen;
        w_inv_n       = r_inv;
        w_done_n      = 1'b0;
        w_busy_n      = 1'b0;
        w_mul_start_n = 1'b0;
        w_mul_a_n     = r_mul_a;
        w_mul_b_n     = r_mul_b;
        w_adv         = 1'b0;
`ifdef SEQ_INV_EXP_PORT_EN
        w_exp_n       = r_exp;
`endif

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_base_n  = x;
                    w_acc_n   = 256'd1;
                    w_i_n     = 8'd254;
                    w_seen_n  = 1'b0;
                    w_state_n = S_LOAD;
`ifdef SEQ_INV_EXP_PORT_EN
                    w_exp_n   = exp;
`endif
                end
            end
            S_LOAD: w_state_n = S_SCAN;
            S_SCAN: begin
                if (r_seen) begin
                    w_state_n = S_SQ_REQ;
                end else begin
                    // leading 1 bit: acc = 1 * base, no multiplier op needed
                    if (w_bit) begin
                        w_acc_n  = r_base;
                        w_seen_n = 1'b1;
                    end
                    w_adv = 1'b1;
                end
            end
            S_SQ_REQ: w_state_n = S_SQ_WAIT;
            S_SQ_WAIT: begin
                if (mul_done) begin
                    w_acc_n = mul_product;
                    if (w_bit) w_state_n = S_MUL_REQ;
                    else       w_adv     = 1'b1;
                end
            end
            S_MUL_REQ: w_state_n = S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (mul_done) begin
                    w_acc_n = mul_product;
                    w_adv   = 1'b1;
                end
            end
            S_FIN:   w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase

        if (w_adv) begin
            if (r_i == 8'd0) begin
                // outputs are registered, so the result and done are loaded
                // on entry to FIN to make FIN itself the done cycle
                w_state_n = S_FIN;
                w_inv_n   = w_acc_n;
                w_done_n  = 1'b1;
            end else begin
                w_i_n     = r_i - 8'd1;
                w_state_n = S_SCAN;
            end
        end

        w_busy_n = (w_state_n != S_IDLE);

        if (w_state_n == S_SQ_REQ) begin
            w_mul_start_n = 1'b1;
            w_mul_a_n     = w_acc_n;
            w_mul_b_n     = w_acc_n;
        end else if (w_state_n == S_MUL_REQ) begin
            w_mul_start_n = 1'b1;
            w_mul_a_n     = w_acc_n;
            w_mul_b_n     = r_base;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_base      <= '0;
            r_i         <= '0;
            r_seen      <= 1'b0;
            r_inv       <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
`ifdef SEQ_INV_EXP_PORT_EN
            r_exp       <= '0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_acc       <= w_acc_n;
            r_base      <= w_base_n;
            r_i         <= w_i_n;
            r_seen      <= w_seen_n;
            r_inv       <= w_inv_n;
            r_done      <= w_done_n;
            r_busy      <= w_busy_n;
            r_mul_start <= w_mul_start_n;
            r_mul_a     <= w_mul_a_n;
            r_mul_b     <= w_mul_b_n;
`ifdef SEQ_INV_EXP_PORT_EN
            r_exp       <= w_exp_n;
`endif
        end
    end

    assign inv       = r_inv;
    assign done      = r_done;
    assign busy      = r_busy;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;

endmodule

// File: doc/seq_inv_25519.md
# seq_inv_25519

Sequential modular inverter over GF(2^255-19): computes inv = x^(p-2) mod p by left-to-right square-and-multiply. It sits directly upstream of the 256-bit sequential field multiplier, issuing every square/multiply to it and consuming each reduced product. It is used by point-decompression and affine-conversion stages. One inversion occupies the multiplier exclusively.

## Interface

- No parameters. Field prime p = 2^255-19 and exponent p-2 are fixed constants.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- x  in  256  operand; must be canonical (x < p); sampled with start
- inv  out  256  result; valid from done until next accepted start
- done  out  1  one-cycle pulse, result ready
- busy  out  1  high from the cycle after start is accepted through the done cycle
- mul_a  out  256  multiplier operand A
- mul_b  out  256  multiplier operand B
- mul_start  out  1  one-cycle pulse, launches one multiply
- mul_product  in  256  reduced product (mod p) from multiplier
- mul_done  in  1  one-cycle pulse, mul_product valid

## Operation

- Registers: acc[255:0], base[255:0], bit index i[7:0], flag seen (a 1 exponent bit has been processed).
- States: IDLE, LOAD, SCAN, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, FIN.
- IDLE: on start, latch base=x, acc=1, i=254, seen=0, go to LOAD. Otherwise hold, with inv unchanged.
- LOAD: one cycle, go to SCAN.
- SCAN (one cycle per exponent bit e[i]):
  - if seen: go to SQ_REQ.
  - else if e[i]=1: acc=base, seen=1, skip multiply, advance.
  - else: advance.
- SQ_REQ: mul_a=mul_b=acc, mul_start=1, go to SQ_WAIT.
- SQ_WAIT: on mul_done, acc=mul_product. If e[i]=1 go to MUL_REQ, else advance.
- MUL_REQ: mul_a=acc, mul_b=base, mul_start=1, go to MUL_WAIT.
- MUL_WAIT: on mul_done, acc=mul_product, advance.
- advance: if i=0 go to FIN, else i=i-1 and go to SCAN.
- FIN: inv=acc, done=1, go to IDLE.
- mul_a/mul_b are held stable from mul_start through mul_done. mul_done outside SQ_WAIT/MUL_WAIT is ignored.
- Op count for p-2 (bits 254..5 =1, bit4=0, bit3=1, bit2=0, bits1..0 =1): 254 squares + 252 multiplies = 506 multiplier ops.
- x=0 yields 0. x must be < p; non-canonical inputs are unsupported.
- start while busy is ignored, with no queuing.

## Timing

- Reset (async): state=IDLE; inv=0, done=0, busy=0, mul_start=0, mul_a=0, mul_b=0; acc/base/i cleared.
- Reset mid-operation aborts immediately. mul_start drops asynchronously. No done is produced. A later mul_done from the abandoned op is ignored in IDLE.
- L = cycles from a mul_start-high cycle to the matching mul_done-high cycle (L≥1). Each op costs L+1 cycles; each SCAN costs 1 cycle.
- done is high exactly 257 + N_ops·(L+1) cycles after the edge that sampled start (LOAD 1 + SCAN 255 + FIN 1). For p-2, N_ops=506.
- A new start is accepted in the cycle after done.

## Configuration

- SEQ_INV_EXP_PORT_EN:
  - Defined: adds input exp[254:0], sampled with start. The block computes x^exp mod p with the same algorithm. exp=0 yields inv=1 with zero mul_start pulses. N_ops = (bits after the leading 1) + (popcount−1).
  - Undefined: exponent hard-wired to p-2, and there is no exp port.

## Test plan

- Mock multiplier (L=1, exact mod-p model), x=2 → inv=0x3FFF…FFF7 (2^254−9). done exactly 1269 cycles after start. Exactly 506 mul_start pulses.
- x=1 → inv=1. x=p−1 → inv=p−1. x=0 → inv=0. Each done pulse is one cycle wide, and busy drops with it.
- Random canonical x, L randomized 1–8 per op → inv·x mod p = 1. mul_a/mul_b stable throughout each op. A start pulsed while busy is ignored.
- rst asserted during the 100th op → outputs zero immediately, no done. Stray mul_done afterwards is ignored. Next start with x=3 completes correctly.
- Spurious mul_done pulses in SCAN/IDLE → no state or acc corruption. Result unchanged vs. clean run.
- With SEQ_INV_EXP_PORT_EN, x=5: exp=3 → inv=125 (1 square + 1 mult). exp=0 → inv=1, no mul_start pulse, done 257 cycles after start.
